// File: rtl/sha256_block_controller.sv
// SHA-256 block sequencer: loads 16 message words into the schedule memory, then drives init/load, 64 rounds and the chaining add.
// Optional abort input is enabled with macro SHA256_CTRL_ABORT_EN.
module sha256_block_controller #(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 sched_wr,
  output logic [3:0]           sched_addr,
  output logic [31:0]          sched_data,
  output logic                 hash_init,
  output logic                 work_load,
  output logic                 round_en,
  output logic [5:0]           round_idx,
  output logic [31:0]          round_k,
  output logic                 hash_accum,
  output logic                 digest_valid,
  input  logic                 digest_ack,
  output logic                 busy,
  output logic                 proto_err,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREP,
    S_ROUNDS,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t      state, next_state;
  logic [3:0]  word_cnt;
  logic        first_q, last_q, chain_open;
  logic        accept, abort_i;
  logic [5:0]  round_nxt;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    logic [31:0] k;
    k = 32'h0;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  assign in_ready     = (state == S_IDLE) || (state == S_LOAD);
  assign accept       = in_valid && in_ready && !abort_i;
  assign hash_init    = (state == S_PREP) && first_q;
  assign work_load    = (state == S_PREP) && !first_q;
  assign round_en     = (state == S_ROUNDS);
  assign hash_accum   = (state == S_ACCUM);
  assign digest_valid = (state == S_DONE);
  assign busy         = (state != S_IDLE);
  assign round_nxt    = (state == S_ROUNDS) ? round_idx + 6'd1 : 6'd0;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = S_LOAD;
      S_LOAD:   if (accept && word_cnt == 4'd15) next_state = S_PREP;
      S_PREP:   next_state = S_ROUNDS;
      S_ROUNDS: if (round_idx == 6'd63) next_state = S_ACCUM;
      S_ACCUM:  next_state = last_q ? S_DONE : S_IDLE;
      S_DONE:   if (digest_ack) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort_i) next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The K constant is fetched alongside the index so both present in the same round cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_idx <= 6'd0;
      round_k   <= 32'h0;
    end else if (next_state == S_ROUNDS) begin
      round_idx <= round_nxt;
      round_k   <= k_const(round_nxt);
    end else begin
      round_idx <= 6'd0;
      round_k   <= 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched_wr   <= 1'b0;
      sched_addr <= 4'd0;
      sched_data <= 32'h0;
      word_cnt   <= 4'd0;
    end else begin
      sched_wr <= accept;
      if (accept) begin
        sched_addr <= word_cnt;
        sched_data <= in_data;
        word_cnt   <= word_cnt + 4'd1;
      end
      if (abort_i) word_cnt <= 4'd0;
    end
  end

  // A non-first block with no open message is flagged and then handled as a fresh message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      chain_open <= 1'b0;
      proto_err  <= 1'b0;
      blk_cnt    <= '0;
    end else if (abort_i) begin
      chain_open <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      if (accept && state == S_IDLE) begin
        first_q <= in_first || !chain_open;
        last_q  <= in_last;
        if (!in_first && !chain_open) proto_err <= 1'b1;
        if (in_first || !chain_open) blk_cnt <= '0;
      end
      if (state == S_ACCUM) begin
        if (blk_cnt != '1) blk_cnt <= blk_cnt + BLK_CNT_W'(1);
        chain_open <= !last_q;
      end
      if (state == S_DONE && digest_ack) blk_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sha256_block_controller.sv
// Directed and randomized bench for sha256_block_controller; expected timing derived from a block-level model.
module tb_sha256_block_controller;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk, rst, in_valid, in_first, in_last, digest_ack;
  logic [31:0] in_data;
  logic        in_ready, sched_wr, hash_init, work_load, round_en, hash_accum;
  logic        digest_valid, busy, proto_err;
  logic [3:0]  sched_addr;
  logic [31:0] sched_data, round_k;
  logic [5:0]  round_idx;
  logic [15:0] blk_cnt;
`ifdef SHA256_CTRL_ABORT_EN
  logic        abort;
`endif

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] w [16];
  logic        m_chain, m_perr;
  logic [15:0] m_blk;

  sha256_block_controller #(.BLK_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
`ifdef SHA256_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .sched_wr(sched_wr), .sched_addr(sched_addr), .sched_data(sched_data),
    .hash_init(hash_init), .work_load(work_load), .round_en(round_en),
    .round_idx(round_idx), .round_k(round_k), .hash_accum(hash_accum),
    .digest_valid(digest_valid), .digest_ack(digest_ack), .busy(busy),
    .proto_err(proto_err), .blk_cnt(blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sched_wr", sched_wr, 0);
    chk("rst_sched_addr", sched_addr, 0);
    chk("rst_sched_data", sched_data, 0);
    chk("rst_strobes", {hash_init, work_load, round_en, hash_accum}, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_round_k", round_k, 0);
    chk("rst_digest_valid", digest_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) w[i] = $urandom;
  endtask

  // Drives one block and checks the whole expected timeline; stop_round >= 0 returns early in that round.
  task automatic run_block(input logic first, input logic last, input bit gappy, input int hold,
                           input bit chk_blk, input int stop_round);
    int   idx, prev_idx;
    bit   acc_prev, tog, v, eff_first;
    eff_first = first || !m_chain;
    idx = 0; prev_idx = 0; acc_prev = 0; tog = 1;
    while (idx < 16) begin
      @(negedge clk);
      chk("load_in_ready", in_ready, 1);
      chk("load_busy", busy, idx > 0);
      chk("load_digest_valid", digest_valid, 0);
      chk("load_sched_wr", sched_wr, acc_prev);
      if (acc_prev) begin
        chk("load_sched_addr", sched_addr, prev_idx);
        chk("load_sched_data", sched_data, w[prev_idx]);
      end
      v = gappy ? tog : 1'b1;
      tog = ~tog;
      in_valid = v;
      in_data = v ? w[idx] : $urandom;
      in_first = (idx == 0) ? first : 1'($urandom);
      in_last = (idx == 0) ? last : 1'($urandom);
      digest_ack = 1'($urandom);
      acc_prev = v; prev_idx = idx;
      if (v) idx++;
    end
    if (!first && !m_chain) m_perr = 1'b1;
    @(negedge clk);
    chk("prep_sched_wr", sched_wr, 1);
    chk("prep_sched_addr", sched_addr, 15);
    chk("prep_sched_data", sched_data, w[15]);
    chk("prep_in_ready", in_ready, 0);
    chk("prep_hash_init", hash_init, eff_first);
    chk("prep_work_load", work_load, !eff_first);
    chk("prep_round_en", round_en, 0);
    chk("prep_proto_err", proto_err, m_perr);
    in_valid = 1'b1; in_data = $urandom; in_first = 1'($urandom); in_last = 1'($urandom);
    for (int r = 0; r < 64; r++) begin
      @(negedge clk);
      chk("rnd_en", round_en, 1);
      chk("rnd_idx", round_idx, r);
      chk("rnd_k", round_k, K_TAB[r]);
      chk("rnd_other_strobes", {hash_init, work_load, hash_accum, digest_valid}, 0);
      chk("rnd_in_ready", in_ready, 0);
      chk("rnd_sched_wr", sched_wr, 0);
      if (r == stop_round) begin
        in_valid = 1'b0; digest_ack = 1'b0;
        return;
      end
      digest_ack = 1'($urandom);
    end
    @(negedge clk);
    chk("acc_hash_accum", hash_accum, 1);
    chk("acc_round_en", round_en, 0);
    chk("acc_in_ready", in_ready, 0);
    m_blk = eff_first ? 16'd1 : ((m_blk == 16'hffff) ? m_blk : m_blk + 16'd1);
    m_chain = !last;
    in_valid = 1'b0; digest_ack = 1'b0;
    if (last) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("done_digest_valid", digest_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("done_strobes", {hash_init, work_load, round_en, hash_accum}, 0);
        if (chk_blk) chk("done_blk_cnt", blk_cnt, m_blk);
        digest_ack = (i == hold - 1);
      end
      @(negedge clk);
      chk("ack_digest_valid", digest_valid, 0);
      chk("ack_busy", busy, 0);
      chk("ack_blk_cnt", blk_cnt, 0);
      digest_ack = 1'b0;
      m_blk = 16'd0;
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_first = 1'b0; in_last = 1'b0; digest_ack = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    m_chain = 1'b0; m_perr = 1'b0; m_blk = 16'd0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;

    // "abc" single block
    w[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) w[i] = 32'h0;
    w[15] = 32'h00000018;
    run_block(1'b1, 1'b1, 1'b0, 10, 1'b1, -1);

    // Two-block message, then a random gappy two-block message
    rand_words(); run_block(1'b1, 1'b0, 1'b0, 0, 1'b1, -1);
    rand_words(); run_block(1'b0, 1'b1, 1'b0, 3, 1'b1, -1);
    rand_words(); run_block(1'b1, 1'b0, 1'b1, 0, 1'b1, -1);
    rand_words(); run_block(1'b0, 1'b1, 1'b1, 2, 1'b1, -1);
    chk("no_proto_err", proto_err, 0);

    // New first block while a chain is open restarts the message
    rand_words(); run_block(1'b1, 1'b0, 1'b0, 0, 1'b1, -1);
    rand_words(); run_block(1'b1, 1'b1, 1'b0, 2, 1'b0, -1);
    chk("restart_proto_err", proto_err, 0);

    // Asynchronous reset in round 30
    rand_words(); run_block(1'b1, 1'b1, 1'b0, 1, 1'b1, 30);
    #2 rst = 1'b0;
    #1;
    chk_reset_vals();
    m_chain = 1'b0; m_perr = 1'b0; m_blk = 16'd0;
    @(negedge clk);
    rst = 1'b1;
    rand_words(); run_block(1'b1, 1'b1, 1'b0, 1, 1'b1, -1);

    // Non-first block with no open message
    rand_words(); run_block(1'b0, 1'b1, 1'b1, 2, 1'b1, -1);
    chk("proto_err_sticky", proto_err, 1);

`ifdef SHA256_CTRL_ABORT_EN
    rand_words(); run_block(1'b1, 1'b1, 1'b0, 1, 1'b1, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_round_en", round_en, 0);
    chk("abort_hash_accum", hash_accum, 0);
    chk("abort_busy", busy, 0);
    chk("abort_blk_cnt", blk_cnt, 0);
    chk("abort_proto_err", proto_err, m_perr);
    m_chain = 1'b0; m_blk = 16'd0;
    rand_words(); run_block(1'b1, 1'b1, 1'b0, 1, 1'b1, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
